// File: rtl/sat_alu_pkg.sv
// Shared types for the pipelined saturating ALU: operation encoding and the
// flag bundle carried alongside each result through the pipeline stages.
package sat_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_PADD = 2'b10,
        OP_ADDW = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } alu_flags_t;

    function automatic alu_flags_t make_flags(input logic sign, input logic zero, input logic ovf);
        alu_flags_t f;
        f.n = sign;
        f.z = zero;
        f.v = ovf;
        return f;
    endfunction

endpackage

// File: rtl/sat_alu_pipe_lane.sv
// Signed W-bit adder with carry-in; reports raw sum, signed overflow and the
// sum clamped to the signed range of W bits.
module sat_add_lane #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         ovf,
    output logic [W-1:0] sat
);

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    assign sum = a + b + {{(W-1){1'b0}}, cin};
    // For subtraction b arrives inverted, so "same sign as b" covers both cases.
    assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    assign sat = ovf ? (a[W-1] ? MIN_NEG : MAX_POS) : sum;

endmodule

// File: rtl/sat_alu_pipe.sv
// Execute-stage saturating ALU: mode mux in front of a PIPE-deep elastic
// pipeline with valid/ready handshake, flush and a sticky overflow bit.
module sat_alu_pipe
    import sat_alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4,
    parameter int PIPE   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             ovfl_sticky,
    input  logic             ovfl_clr
);

    localparam int NL = WIDTH / LANE_W;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_flags_t       flags;
    } stage_t;

    alu_op_e          mode;
    logic             is_sub;
    logic [WIDTH-1:0] full_b;
    logic [WIDTH-1:0] full_sum;
    logic [WIDTH-1:0] full_sat;
    logic             full_ovf;
    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_sat;
    logic [NL-1:0]    lane_ovf;
    logic [WIDTH-1:0] res;
    logic             res_v;
    stage_t           comp;

    assign mode   = alu_op_e'(op);
    assign is_sub = (mode == OP_SUB);
    assign full_b = is_sub ? ~b : b;

    sat_add_lane #(.W(WIDTH)) u_full (
        .a   (a),
        .b   (full_b),
        .cin (is_sub),
        .sum (full_sum),
        .ovf (full_ovf),
        .sat (full_sat)
    );

    for (genvar i = 0; i < NL; i++) begin : g_lane
        sat_add_lane #(.W(LANE_W)) u_lane (
            .a   (a[i*LANE_W +: LANE_W]),
            .b   (b[i*LANE_W +: LANE_W]),
            .cin (1'b0),
            .sum (lane_sum[i*LANE_W +: LANE_W]),
            .ovf (lane_ovf[i]),
            .sat (lane_sat[i*LANE_W +: LANE_W])
        );
    end

    // Packed lanes only ever deliver their clamped value.
    logic unused_lane_sum;
    assign unused_lane_sum = ^lane_sum;

    always_comb begin
        res   = '0;
        res_v = 1'b0;
        case (mode)
            OP_ADD, OP_SUB: begin
                res   = full_sat;
                res_v = full_ovf;
            end
            OP_PADD: begin
                res   = lane_sat;
                res_v = |lane_ovf;
            end
            OP_ADDW: begin
                res   = full_sum;
                res_v = full_ovf;
            end
            default: begin
                res   = '0;
                res_v = 1'b0;
            end
        endcase
        comp.result = res;
        comp.flags  = make_flags(res[WIDTH-1], res == '0, res_v);
    end

    logic [PIPE-1:0] vld;
    stage_t          stg [PIPE];
    logic [PIPE:0]   rdy;
    logic            accept;

    // A stage can load when it is empty or its content moves on this cycle.
    always_comb begin
        rdy       = '0;
        rdy[PIPE] = out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            rdy[k] = !vld[k] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0] && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < PIPE; k++) begin
                stg[k] <= '0;
            end
        end else if (flush) begin
            vld <= '0;
        end else begin
            if (rdy[0]) begin
                vld[0] <= accept;
                if (accept) begin
                    stg[0] <= comp;
                end
            end
            for (int k = 1; k < PIPE; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        stg[k] <= stg[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld[PIPE-1];
    assign result    = stg[PIPE-1].result;
    assign flag_n    = stg[PIPE-1].flags.n;
    assign flag_z    = stg[PIPE-1].flags.z;
    assign flag_v    = stg[PIPE-1].flags.v;

    // A delivery with overflow takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovfl_sticky <= 1'b0;
        end else if (out_valid && out_ready && flag_v) begin
            ovfl_sticky <= 1'b1;
        end else if (ovfl_clr) begin
            ovfl_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sat_alu_pipe.sv
// Directed-vector bench for sat_alu_pipe (WIDTH=16, LANE_W=4, PIPE=2).
module tb_sat_alu_pipe;
    import sat_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;
    logic        ovfl_sticky;
    logic        ovfl_clr;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sat_alu_pipe #(.WIDTH(16), .LANE_W(4), .PIPE(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .flag_v      (flag_v),
        .ovfl_sticky (ovfl_sticky),
        .ovfl_clr    (ovfl_clr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
        flush = 1'b0; out_ready = 1'b0; ovfl_clr = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v, ovfl_sticky, in_ready} !== {1'b0, 16'h0000, 4'b0000, 1'b1})
            $display("FAIL reset: got ov=%b res=%h nzv=%b%b%b st=%b ir=%b expected 0 0000 000 0 1",
                     out_valid, result, flag_n, flag_z, flag_v, ovfl_sticky, in_ready);
        else passed++;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(OP_ADD, 16'h7000, 16'h2000);
        cyc();
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v} !== {1'b1, 16'h7FFF, 3'b001})
            $display("FAIL add_pos_sat: got ov=%b res=%h nzv=%b%b%b expected 1 7fff 001",
                     out_valid, result, flag_n, flag_z, flag_v);
        else passed++;
        cyc();
        checks++;
        if ({out_valid, ovfl_sticky} !== 2'b01)
            $display("FAIL add_sticky: got ov=%b st=%b expected 0 1", out_valid, ovfl_sticky);
        else passed++;
        issue(OP_ADD, 16'h8000, 16'hFFFF);
        cyc();
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v} !== {1'b1, 16'h8000, 3'b101})
            $display("FAIL add_neg_sat: got ov=%b res=%h nzv=%b%b%b expected 1 8000 101",
                     out_valid, result, flag_n, flag_z, flag_v);
        else passed++;
        cyc();
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        issue(OP_SUB, 16'h8000, 16'h0001);
        cyc();
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v} !== {1'b1, 16'h8000, 3'b101})
            $display("FAIL sub_neg_sat: got ov=%b res=%h nzv=%b%b%b expected 1 8000 101",
                     out_valid, result, flag_n, flag_z, flag_v);
        else passed++;
        cyc();
        issue(OP_SUB, 16'h1234, 16'h1234);
        cyc();
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v} !== {1'b1, 16'h0000, 3'b010})
            $display("FAIL sub_zero: got ov=%b res=%h nzv=%b%b%b expected 1 0000 010",
                     out_valid, result, flag_n, flag_z, flag_v);
        else passed++;
        cyc();
    endtask

    task automatic test_padd();
        out_ready = 1'b1;
        issue(OP_PADD, 16'h7878, 16'h1111);
        cyc();
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v} !== {1'b1, 16'h7979, 3'b001})
            $display("FAIL padd_ovf: got ov=%b res=%h nzv=%b%b%b expected 1 7979 001",
                     out_valid, result, flag_n, flag_z, flag_v);
        else passed++;
        cyc();
        issue(OP_PADD, 16'h1234, 16'h1111);
        cyc();
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v} !== {1'b1, 16'h2345, 3'b000})
            $display("FAIL padd_plain: got ov=%b res=%h nzv=%b%b%b expected 1 2345 000",
                     out_valid, result, flag_n, flag_z, flag_v);
        else passed++;
        cyc();
        issue(OP_PADD, 16'h8888, 16'h8888);
        cyc();
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v} !== {1'b1, 16'h8888, 3'b101})
            $display("FAIL padd_neg_sat: got ov=%b res=%h nzv=%b%b%b expected 1 8888 101",
                     out_valid, result, flag_n, flag_z, flag_v);
        else passed++;
        cyc();
    endtask

    task automatic test_addw();
        out_ready = 1'b1;
        issue(OP_ADDW, 16'h7FFF, 16'h0001);
        cyc();
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v} !== {1'b1, 16'h8000, 3'b101})
            $display("FAIL addw_wrap: got ov=%b res=%h nzv=%b%b%b expected 1 8000 101",
                     out_valid, result, flag_n, flag_z, flag_v);
        else passed++;
        cyc();
        issue(OP_ADDW, 16'hFFFF, 16'h0001);
        cyc();
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v} !== {1'b1, 16'h0000, 3'b010})
            $display("FAIL addw_zero: got ov=%b res=%h nzv=%b%b%b expected 1 0000 010",
                     out_valid, result, flag_n, flag_z, flag_v);
        else passed++;
        cyc();
    endtask

    task automatic test_sticky_clr();
        out_ready = 1'b1;
        ovfl_clr = 1'b1;
        cyc();
        ovfl_clr = 1'b0;
        checks++;
        if (ovfl_sticky !== 1'b0)
            $display("FAIL sticky_clear: got %b expected 0", ovfl_sticky);
        else passed++;
        issue(OP_ADD, 16'h7000, 16'h2000);
        cyc();
        ovfl_clr = 1'b1;
        cyc();
        ovfl_clr = 1'b0;
        checks++;
        if (ovfl_sticky !== 1'b1)
            $display("FAIL sticky_set_wins: got %b expected 1", ovfl_sticky);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  vop [3];
        logic [15:0] va  [3];
        logic [15:0] vb  [3];
        logic [15:0] vexp[3];
        logic [15:0] got [3];
        int          when[3];
        int          idx;
        int          n;
        int          extra;
        logic        fire;
        vop[0] = OP_ADD; va[0] = 16'h0001; vb[0] = 16'h0002; vexp[0] = 16'h0003;
        vop[1] = OP_ADD; va[1] = 16'h0010; vb[1] = 16'h0020; vexp[1] = 16'h0030;
        vop[2] = OP_SUB; va[2] = 16'h0005; vb[2] = 16'h0007; vexp[2] = 16'hFFFE;
        idx = 0; n = 0; extra = 0;
        for (int i = 0; i < 3; i++) begin
            got[i] = '0;
            when[i] = -1;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            op = vop[idx]; a = va[idx]; b = vb[idx];
            #1;
            fire = in_ready;
            cyc();
            if (fire) idx++;
        end
        checks++;
        if ({idx[3:0], in_ready} !== {4'd2, 1'b0})
            $display("FAIL bp_accept: got accepted=%0d in_ready=%b expected 2 0", idx, in_ready);
        else passed++;
        cyc();
        checks++;
        if ({out_valid, result} !== {1'b1, 16'h0003})
            $display("FAIL bp_hold: got ov=%b res=%h expected 1 0003", out_valid, result);
        else passed++;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin
                op = vop[idx]; a = va[idx]; b = vb[idx];
            end
            #1;
            fire = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (n < 3) begin
                    got[n] = result;
                    when[n] = c;
                    n++;
                end else extra++;
            end
            cyc();
            if (fire) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if ({n[3:0], extra[3:0]} !== {4'd3, 4'd0})
            $display("FAIL bp_count: got delivered=%0d extra=%0d expected 3 0", n, extra);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== vexp[i])
                $display("FAIL bp_order%0d: got %h expected %h", i, got[i], vexp[i]);
            else passed++;
        end
        checks++;
        if (when[2] - when[0] !== 2)
            $display("FAIL bp_throughput: got span=%0d cycles expected 2", when[2] - when[0]);
        else passed++;
    endtask

    task automatic test_flush();
        ovfl_clr = 1'b1;
        cyc();
        ovfl_clr = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; op = OP_ADD; a = 16'h7000; b = 16'h2000;
        repeat (2) cyc();
        checks++;
        if ({out_valid, in_ready} !== 2'b10)
            $display("FAIL flush_fill: got ov=%b ir=%b expected 1 0", out_valid, in_ready);
        else passed++;
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0)
            $display("FAIL flush_in_ready: got %b expected 0", in_ready);
        else passed++;
        out_ready = 1'b0;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, ovfl_sticky} !== 2'b00)
            $display("FAIL flush_drop: got ov=%b st=%b expected 0 0", out_valid, ovfl_sticky);
        else passed++;
        out_ready = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({out_valid, ovfl_sticky} !== 2'b00)
            $display("FAIL flush_quiet: got ov=%b st=%b expected 0 0", out_valid, ovfl_sticky);
        else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        issue(OP_ADD, 16'h7000, 16'h2000);
        repeat (2) cyc();
        checks++;
        if (ovfl_sticky !== 1'b1)
            $display("FAIL rst_pre_sticky: got %b expected 1", ovfl_sticky);
        else passed++;
        out_ready = 1'b0;
        in_valid = 1'b1; op = OP_ADD; a = 16'h1234; b = 16'h0001;
        repeat (2) cyc();
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if ({out_valid, result, flag_n, flag_z, flag_v, ovfl_sticky} !== {1'b0, 16'h0000, 4'b0000})
            $display("FAIL rst_mid: got ov=%b res=%h nzv=%b%b%b st=%b expected 0 0000 000 0",
                     out_valid, result, flag_n, flag_z, flag_v, ovfl_sticky);
        else passed++;
        out_ready = 1'b1;
        repeat (3) cyc();
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL rst_no_output: got ov=%b expected 0", out_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_padd();
        test_addw();
        test_sticky_clr();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
